line_buffer_3row: RTL and testbench

//  Converts a raster pixel stream (one RGB pixel per valid beat) into three vertically aligned rows.

---
 rtl/line_buffer_3row.sv | 123 ++++++++++++
 tb/tb_line_buffer_3row.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_3row.sv
// ---------------------------------------------------------------------------
// line_buffer_3row
//   Turns a raster RGB pixel stream into three vertically aligned rows, one
//   column per beat, for the downstream 3x3 window stage. Two circular line
//   memories hold the previous two lines. Output is qualified only after two
//   complete lines have been stored in the current frame.
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   i_sof        in   start-of-frame pulse, resynchronises counters
//   i_valid_in   in   i_pix_in valid this cycle
//   i_pix_in     in   [WIDTH-1:0] current pixel, raster order
//   o_valid_out  out  registered output beat valid
//   o_dout1      out  [WIDTH-1:0] pixel at (row-2, col), oldest line
//   o_dout2      out  [WIDTH-1:0] pixel at (row-1, col)
//   o_dout3      out  [WIDTH-1:0] pixel at (row,   col), current line
//   o_eol        out  with o_valid_out: last column of a line
//   o_eof        out  with o_valid_out: last pixel of the frame
// ---------------------------------------------------------------------------
module line_buffer_3row #(
    parameter int WIDTH      = 24,
    parameter int PIC_WIDTH  = 320,
    parameter int PIC_HEIGHT = 240
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sof,
    input  logic             i_valid_in,
    input  logic [WIDTH-1:0] i_pix_in,
    output logic             o_valid_out,
    output logic [WIDTH-1:0] o_dout1,
    output logic [WIDTH-1:0] o_dout2,
    output logic [WIDTH-1:0] o_dout3,
    output logic             o_eol,
    output logic             o_eof
);

    localparam int         AW       = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam logic [8:0] LAST_COL = 9'(PIC_WIDTH - 1);
    localparam logic [8:0] LAST_ROW = 9'(PIC_HEIGHT - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t           r_state;
    logic [8:0]       r_col;
    logic [8:0]       r_row;

    // mem0 holds line row-1, mem1 holds line row-2, both indexed by column
    logic [WIDTH-1:0] r_mem0 [0:PIC_WIDTH-1];
    logic [WIDTH-1:0] r_mem1 [0:PIC_WIDTH-1];

    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_rd0;
    logic [WIDTH-1:0] w_rd1;
    logic             w_last_col;
    logic             w_last_row;

    // A beat arriving with sof is the (0,0) pixel of a new frame
    assign w_addr     = i_sof ? '0 : r_col[AW-1:0];
    assign w_rd0      = r_mem0[w_addr];
    assign w_rd1      = r_mem1[w_addr];
    assign w_last_col = (r_col == LAST_COL);
    assign w_last_row = (r_row == LAST_ROW);

    // Line memories are never reset; stale contents are unreachable because
    // output is only qualified after two full lines have been rewritten.
    always_ff @(posedge clk) begin
        if (i_valid_in) begin
            r_mem1[w_addr] <= w_rd0;
            r_mem0[w_addr] <= i_pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_col       <= '0;
            r_row       <= '0;
            o_valid_out <= 1'b0;
            o_eol       <= 1'b0;
            o_eof       <= 1'b0;
            o_dout1     <= '0;
            o_dout2     <= '0;
            o_dout3     <= '0;
        end else begin
            o_valid_out <= 1'b0;
            o_eol       <= 1'b0;
            o_eof       <= 1'b0;

            if (i_valid_in) begin
                o_dout3 <= i_pix_in;
                o_dout2 <= w_rd0;
                o_dout1 <= w_rd1;
            end

            if (i_sof) begin
                r_state <= FILL;
                r_row   <= '0;
                // sof beat occupies column 0, so the next beat is column 1
                r_col   <= i_valid_in ? 9'd1 : 9'd0;
            end else if (i_valid_in) begin
                o_valid_out <= (r_state == RUN);
                o_eol       <= (r_state == RUN) && w_last_col;
                o_eof       <= (r_state == RUN) && w_last_col && w_last_row;

                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? 9'd0 : r_row + 9'd1;
                end else begin
                    r_col <= r_col + 9'd1;
                end

                case (r_state)
                    FILL: if (w_last_col && r_row == 9'd1) r_state <= RUN;
                    RUN:  if (w_last_col && w_last_row)    r_state <= FILL;
                    default: r_state <= FILL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_3row.sv
module tb_line_buffer_3row;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sof;
    logic        valid_in;
    logic [23:0] pix_in;
    logic        valid_out;
    logic [23:0] dout1, dout2, dout3;
    logic        eol, eof;

    int n_chk  = 0;
    int n_fail = 0;

    line_buffer_3row #(.WIDTH(24), .PIC_WIDTH(4), .PIC_HEIGHT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sof      (sof),
        .i_valid_in (valid_in),
        .i_pix_in   (pix_in),
        .o_valid_out(valid_out),
        .o_dout1    (dout1),
        .o_dout2    (dout2),
        .o_dout3    (dout3),
        .o_eol      (eol),
        .o_eof      (eof)
    );

    always #5 clk = ~clk;

    // drive on the falling edge, sample 1 ns after the rising edge
    task automatic send(input logic [23:0] px, input logic s, input logic v);
        @(negedge clk);
        pix_in   = px;
        sof      = s;
        valid_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sof = 1'b0; valid_in = 1'b0; pix_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({valid_out, eol, eof} !== 3'b000 || dout1 !== 24'h0 || dout2 !== 24'h0 || dout3 !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b eol=%b eof=%b d1=%h d2=%h d3=%h exp all zero",
                     valid_out, eol, eof, dout1, dout2, dout3);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One 4x4 frame with pix = {tag,row,col}; checks every beat and gap,
    // then the per-frame beat / eol / eof totals.
    task automatic test_frame(input bit gaps, input logic [7:0] tag, input string name);
        int nv = 0, ne = 0, nf = 0;
        bit have = 0;
        logic [23:0] e1 = '0, e2 = '0, e3 = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (gaps) begin
                    for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                        send(24'hABCDEF, 1'b0, 1'b0);
                        n_chk++;
                        if ({valid_out, eol, eof} !== 3'b000) begin
                            n_fail++;
                            $display("FAIL %s gap_flags r%0d c%0d got v=%b eol=%b eof=%b exp 000",
                                     name, r, c, valid_out, eol, eof);
                        end
                        if (have) begin
                            n_chk++;
                            if (dout1 !== e1 || dout2 !== e2 || dout3 !== e3) begin
                                n_fail++;
                                $display("FAIL %s gap_hold r%0d c%0d got %h %h %h exp %h %h %h",
                                         name, r, c, dout1, dout2, dout3, e1, e2, e3);
                            end
                        end
                    end
                end
                send({tag, 8'(r), 8'(c)}, 1'b0, 1'b1);
                nv += int'(valid_out); ne += int'(eol); nf += int'(eof);
                n_chk++;
                if (valid_out !== (r >= 2)) begin
                    n_fail++;
                    $display("FAIL %s valid_out r%0d c%0d got %b exp %b", name, r, c, valid_out, (r >= 2));
                end
                if (r >= 2) begin
                    e1 = {tag, 8'(r - 2), 8'(c)};
                    e2 = {tag, 8'(r - 1), 8'(c)};
                    e3 = {tag, 8'(r), 8'(c)};
                    have = 1;
                    n_chk++;
                    if (dout1 !== e1 || dout2 !== e2 || dout3 !== e3) begin
                        n_fail++;
                        $display("FAIL %s dout r%0d c%0d got %h %h %h exp %h %h %h",
                                 name, r, c, dout1, dout2, dout3, e1, e2, e3);
                    end
                    n_chk++;
                    if (eol !== (c == 3) || eof !== (r == 3 && c == 3)) begin
                        n_fail++;
                        $display("FAIL %s flags r%0d c%0d got eol=%b eof=%b exp eol=%b eof=%b",
                                 name, r, c, eol, eof, (c == 3), (r == 3 && c == 3));
                    end
                end else begin
                    n_chk++;
                    if (eol !== 1'b0 || eof !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s fill_flags r%0d c%0d got eol=%b eof=%b exp 0 0", name, r, c, eol, eof);
                    end
                end
            end
        end
        n_chk++;
        if (nv != 8 || ne != 2 || nf != 1) begin
            n_fail++;
            $display("FAIL %s totals got valid=%0d eol=%0d eof=%0d exp 8 2 1", name, nv, ne, nf);
        end
        send(24'h0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_frame(1'b0, 8'h10, "b2b_f1");
        test_frame(1'b0, 8'h20, "b2b_f2");
    endtask

    task automatic test_sof_mid_frame();
        int nv = 0;
        for (int i = 0; i < 9; i++) send({8'h0, 8'(i / 4), 8'(i % 4)}, 1'b0, 1'b1);
        n_chk++;
        if (valid_out !== 1'b1 || dout3 !== 24'h000200) begin
            n_fail++;
            $display("FAIL sof_pre got v=%b d3=%h exp 1 000200", valid_out, dout3);
        end
        // old pixel (2,1) lands as the new frame's (0,0)
        send(24'h000201, 1'b1, 1'b1);
        n_chk++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL sof_beat valid_out got %b exp 0", valid_out);
        end
        for (int i = 1; i < 8; i++) begin
            send({8'h0, 8'(i / 4), 8'(i % 4)}, 1'b0, 1'b1);
            nv += int'(valid_out);
        end
        n_chk++;
        if (nv != 0) begin
            n_fail++;
            $display("FAIL sof_fill valid beats got %0d exp 0", nv);
        end
        send(24'h000200, 1'b0, 1'b1);
        n_chk++;
        if (valid_out !== 1'b1 || dout1 !== 24'h000201 || dout2 !== 24'h000100 || dout3 !== 24'h000200) begin
            n_fail++;
            $display("FAIL sof_first_out got v=%b %h %h %h exp 1 000201 000100 000200",
                     valid_out, dout1, dout2, dout3);
        end
        nv = 1;
        for (int i = 9; i < 16; i++) begin
            send({8'h0, 8'(i / 4), 8'(i % 4)}, 1'b0, 1'b1);
            nv += int'(valid_out);
        end
        n_chk++;
        if (nv != 8 || eof !== 1'b1) begin
            n_fail++;
            $display("FAIL sof_frame_end got valid=%0d eof=%b exp 8 1", nv, eof);
        end
        send(24'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 11; i++) send({8'h0, 8'(i / 4), 8'(i % 4)}, 1'b0, 1'b1);
        n_chk++;
        if (valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre valid_out got %b exp 1", valid_out);
        end
        @(negedge clk);
        valid_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({valid_out, eol, eof} !== 3'b000 || dout1 !== 24'h0 || dout2 !== 24'h0 || dout3 !== 24'h0) begin
            n_fail++;
            $display("FAIL rst_async got v=%b %h %h %h exp 0 0 0 0", valid_out, dout1, dout2, dout3);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_frame(1'b0, 8'h00, "after_rst");
    endtask

    initial begin
        test_reset();
        test_frame(1'b0, 8'h00, "frame");
        test_frame(1'b1, 8'h00, "gaps");
        test_back_to_back();
        test_sof_mid_frame();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule
